// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM-stage data-memory access controller:
//   - state_e              : controller FSM states (IDLE/REQ/WAIT/DONE)
//   - MEM_ERR_DATA         : value presented on memoryOut after a timeout abort
//   - MEM_WR_DATA          : value presented on memoryOut after a store or a
//                            misaligned access
//   - MEM_TIMEOUT_DEFAULT  : default maximum number of WAIT cycles
//   - MEM_CNT_W            : width of the saturating timeout counter
// -----------------------------------------------------------------------------
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [15:0] MEM_ERR_DATA        = 16'hFFFF;
  localparam logic [15:0] MEM_WR_DATA         = 16'h0000;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;
  localparam int unsigned MEM_CNT_W           = 8;

endpackage : mem_access_pkg

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Bus between the access controller and the multi-cycle data memory.
//   dmem_addr  [15:0]  controller -> memory  registered access address
//   dmem_wdata [15:0]  controller -> memory  registered store data
//   dmem_rd            controller -> memory  one-cycle read strobe
//   dmem_wr            controller -> memory  one-cycle write strobe
//   dmem_rdata [15:0]  memory -> controller  read data, valid with dmem_done
//   dmem_done          memory -> controller  one-cycle completion pulse
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;

  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [15:0] dmem_rdata;
  logic        dmem_done;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_rd,
    output dmem_wr,
    input  dmem_rdata,
    input  dmem_done
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_rd,
    input  dmem_wr,
    output dmem_rdata,
    output dmem_done
  );

endinterface : mem_access_ctrl_if

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mem_timeout_ctr
// 8-bit saturating clear/increment counter that bounds the time the access
// controller spends waiting for the data memory.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   clr_i      in   synchronous clear (has priority over inc_i)
//   inc_i      in   increment by one, saturating at 8'hFF
//   cnt_o      out  current count
//   expired_o  out  high when the count after this cycle reaches TIMEOUT
// Parameter TIMEOUT: number of counted cycles before expiry (1..255).
// -----------------------------------------------------------------------------
module mem_timeout_ctr
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [MEM_CNT_W-1:0] cnt_o,
  output logic                 expired_o
);

  localparam logic [MEM_CNT_W:0] LIMIT = (MEM_CNT_W+1)'(TIMEOUT);

  logic [MEM_CNT_W-1:0] cnt_q;
  logic [MEM_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {MEM_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count is cleared on entry to WAIT, so the current WAIT cycle is
  // number cnt_q+1; expiry fires in the TIMEOUT-th WAIT cycle.
  assign expired_o = ({1'b0, cnt_q} + 1'b1) >= LIMIT;
  assign cnt_o     = cnt_q;

endmodule : mem_timeout_ctr

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage data-memory access controller. Turns a decoded load/store into a
// single strobe to a multi-cycle memory, stalls the pipeline until the memory
// responds (or a timeout aborts the access), then presents the result.
//   clk           in   clock, all state on the rising edge
//   rst           in   asynchronous active-low reset
//   addr [15:0]   in   effective address from EX/MEM
//   wdata[15:0]   in   store data
//   memRead       in   load present in MEM
//   memWrite      in   store present in MEM (wins when both are set)
//   halt          in   blocks new accesses; does not cancel one in flight
//   dmem          --   mem_access_ctrl_if.master, memory request/response bus
//   memoryOut[15:0] out load result / 16'h0000 on store / 16'hFFFF on timeout
//   dataMemStall  out  combinational pipeline stall
//   err           out  one-cycle pulse in DONE when the access was aborted
// Parameter TIMEOUT (1..255): maximum WAIT cycles before abort.
// Build option MEM_ACCESS_ALIGN_CHECK_EN: when defined, odd addresses are
// rejected without touching the memory (err=1, memoryOut=16'h0000).
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        addr,
  input  logic [15:0]        wdata,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic               halt,
  mem_access_ctrl_if.master  dmem,
  output logic [15:0]        memoryOut,
  output logic               dataMemStall,
  output logic               err
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        op_wr_q, op_wr_d;     // access in flight is a store
  logic [15:0] out_q, out_d;
  logic        err_q, err_d;

  logic        acc;
  logic        misalign;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        cnt_expired;
  logic [MEM_CNT_W-1:0] cnt_unused;

  assign acc = (memRead | memWrite) & ~halt;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = addr[0];
`else
  assign misalign = 1'b0;
`endif

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .cnt_o     (cnt_unused),
    .expired_o (cnt_expired)
  );

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    op_wr_d = op_wr_q;
    out_d   = out_q;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (misalign) begin
            // Rejected without a memory cycle: one stall cycle, then DONE.
            state_d = DONE;
            err_d   = 1'b1;
            out_d   = MEM_WR_DATA;
          end else begin
            state_d = REQ;
            addr_d  = addr;
            wdata_d = wdata;
            op_wr_d = memWrite;
            rd_d    = ~memWrite;
            wr_d    = memWrite;
          end
        end
      end

      REQ: begin
        if (dmem.dmem_done) begin
          state_d = DONE;
          out_d   = op_wr_q ? MEM_WR_DATA : dmem.dmem_rdata;
        end else begin
          state_d = WAIT;
          cnt_clr = 1'b1;
        end
      end

      WAIT: begin
        cnt_inc = 1'b1;
        // A response in the last allowed cycle still completes normally.
        if (dmem.dmem_done) begin
          state_d = DONE;
          out_d   = op_wr_q ? MEM_WR_DATA : dmem.dmem_rdata;
        end else if (cnt_expired) begin
          state_d = DONE;
          err_d   = 1'b1;
          out_d   = MEM_ERR_DATA;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  // NOTE: every register here, including the data holding registers, is put
  // in a known state by reset so an abandoned request leaves nothing stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_wr_q <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      op_wr_q <= op_wr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Stall is combinational so a new access freezes the pipeline in the very
  // cycle it appears; DONE is the only cycle in which the pipeline advances.
  assign dataMemStall = ((state_q == IDLE) & acc) |
                        (state_q == REQ) | (state_q == WAIT);

  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_rd    = rd_q;
  assign dmem.dmem_wr    = wr_q;
  assign memoryOut       = out_q;
  assign err             = err_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl (TIMEOUT=4). A memory responder
// answers N cycles after the strobe (N=1 means in the strobe cycle, N=0 means
// never). Expected stall length, strobes and results come from the access
// rules: stall N+1 cycles, or TIMEOUT+2 on timeout, or 1 on a rejected odd
// address when MEM_ACCESS_ALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wdata;
  logic        memRead, memWrite, halt;
  logic [15:0] memoryOut;
  logic        dataMemStall, err;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_out = 16'h0000;   // expected held value of memoryOut

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .wdata        (wdata),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .halt         (halt),
    .dmem         (bus),
    .memoryOut    (memoryOut),
    .dataMemStall (dataMemStall),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete access: drive it, answer it, and check everything up to and
  // including the DONE cycle (plus an idle cycle with a stray done unless b2b).
  task automatic do_access(input bit rd_in, input bit wr_in,
                           input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] rv, input int n,
                           input bit halt_mid, input bit b2b,
                           input string name);
    bit          mis, tmo, is_wr, done_seen;
    int          exp_stall, stall_cnt, rd_cnt, wr_cnt, err_early, req_cyc;
    logic [15:0] exp_mo, got_addr, got_wdata;
    is_wr = wr_in;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    mis = a[0];
`else
    mis = 1'b0;
`endif
    tmo       = !mis && (n == 0 || n > int'(TO) + 1);
    exp_stall = mis ? 1 : (tmo ? int'(TO) + 2 : n + 1);
    exp_mo    = mis ? 16'h0000 : (tmo ? 16'hFFFF : (is_wr ? 16'h0000 : rv));
    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; err_early = 0; req_cyc = -1;
    done_seen = 1'b0; got_addr = '0; got_wdata = '0;

    for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
      @(negedge clk);
      bus.dmem_done  = 1'b0;
      bus.dmem_rdata = 16'($urandom);
      if (cyc == 0) begin
        memRead = rd_in; memWrite = wr_in; addr = a; wdata = wd; halt = 1'b0;
      end
      if (halt_mid && cyc == 2) halt = 1'b1;
      #1;
      if (!dataMemStall && cyc > 0) begin
        done_seen = 1'b1;
        checks++;
        if (stall_cnt !== exp_stall) begin
          errors++;
          $display("FAIL %s stall_cycles got %0d want %0d", name, stall_cnt, exp_stall);
        end
        checks++;
        if (rd_cnt !== int'(!mis && !is_wr)) begin
          errors++;
          $display("FAIL %s rd_pulses got %0d want %0d", name, rd_cnt, int'(!mis && !is_wr));
        end
        checks++;
        if (wr_cnt !== int'(!mis && is_wr)) begin
          errors++;
          $display("FAIL %s wr_pulses got %0d want %0d", name, wr_cnt, int'(!mis && is_wr));
        end
        if (!mis) begin
          checks++;
          if (got_addr !== a) begin
            errors++;
            $display("FAIL %s dmem_addr got %h want %h", name, got_addr, a);
          end
        end
        if (!mis && is_wr) begin
          checks++;
          if (got_wdata !== wd) begin
            errors++;
            $display("FAIL %s dmem_wdata got %h want %h", name, got_wdata, wd);
          end
        end
        checks++;
        if (memoryOut !== exp_mo) begin
          errors++;
          $display("FAIL %s memoryOut got %h want %h", name, memoryOut, exp_mo);
        end
        checks++;
        if (err !== (mis || tmo)) begin
          errors++;
          $display("FAIL %s err_in_done got %b want %b", name, err, mis || tmo);
        end
        checks++;
        if (err_early !== 0) begin
          errors++;
          $display("FAIL %s err_outside_done got %0d want 0", name, err_early);
        end
        bus.dmem_done = 1'b1;   // a response landing in DONE must be ignored
      end else begin
        if (dataMemStall) stall_cnt++;
        if (err) err_early++;
        if (bus.dmem_rd) begin rd_cnt++; got_addr = bus.dmem_addr; end
        if (bus.dmem_wr) begin
          wr_cnt++; got_addr = bus.dmem_addr; got_wdata = bus.dmem_wdata;
        end
        if ((bus.dmem_rd || bus.dmem_wr) && req_cyc < 0) req_cyc = cyc;
        if (n > 0 && req_cyc >= 0 && cyc == req_cyc + n - 1) begin
          bus.dmem_done = 1'b1; bus.dmem_rdata = rv;
        end
      end
    end
    if (!done_seen) begin
      checks++; errors++;
      $display("FAIL %s no_done_cycle got none want DONE within 64 cycles", name);
    end
    model_out = exp_mo;

    if (!b2b) begin
      @(negedge clk);
      memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
      bus.dmem_done = 1'b1; bus.dmem_rdata = 16'($urandom);
      #1;
      checks++;
      if (dataMemStall !== 1'b0 || bus.dmem_rd !== 1'b0 || bus.dmem_wr !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_after got stall=%b rd=%b wr=%b want 0 0 0",
                 name, dataMemStall, bus.dmem_rd, bus.dmem_wr);
      end
      @(negedge clk);
      bus.dmem_done = 1'b0;
      #1;
      checks++;
      if (memoryOut !== exp_mo || err !== 1'b0) begin
        errors++;
        $display("FAIL %s hold_after got out=%h err=%b want out=%h err=0",
                 name, memoryOut, err, exp_mo);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
    addr = '0; wdata = '0; bus.dmem_done = 1'b0; bus.dmem_rdata = '0;
    #12;
    checks++;
    if ({memoryOut, bus.dmem_addr, bus.dmem_wdata, bus.dmem_rd, bus.dmem_wr,
         dataMemStall, err} !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs got out=%h addr=%h wdata=%h rd=%b wr=%b stall=%b err=%b want all 0",
               memoryOut, bus.dmem_addr, bus.dmem_wdata, bus.dmem_rd, bus.dmem_wr,
               dataMemStall, err);
    end
    memRead = 1'b1;   // IDLE & acc must raise stall even while held in reset
    #1;
    checks++;
    if (dataMemStall !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_stall got %b want 1", dataMemStall);
    end
    memRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_out = 16'h0000;
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin memRead = 1'b1; addr = 16'h0080; end
    end
    #1;
    checks++;
    if (dataMemStall !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre_stall got %b want 1", dataMemStall);
    end
    memRead = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if ({memoryOut, bus.dmem_addr, bus.dmem_wdata, bus.dmem_rd, bus.dmem_wr,
         dataMemStall, err} !== 52'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got out=%h addr=%h rd=%b wr=%b stall=%b err=%b want all 0",
               memoryOut, bus.dmem_addr, bus.dmem_rd, bus.dmem_wr, dataMemStall, err);
    end
    memRead = 1'b1;
    #1;
    checks++;
    if (dataMemStall !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state_idle got stall=%b want 1", dataMemStall);
    end
    memRead = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_out = 16'h0000;
    do_access(1'b1, 1'b0, 16'h0044, 16'h0000, 16'hCAFE, 2, 1'b0, 1'b0, "after_reset_load");
  endtask

  task automatic test_halt();
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      memRead = 1'b1; halt = 1'b1; addr = 16'h0022;
      #1;
      checks++;
      if (dataMemStall !== 1'b0 || bus.dmem_rd !== 1'b0 || bus.dmem_wr !== 1'b0) begin
        errors++;
        $display("FAIL halt_block got stall=%b rd=%b wr=%b want 0 0 0",
                 dataMemStall, bus.dmem_rd, bus.dmem_wr);
      end
    end
    @(negedge clk);
    memRead = 1'b0; halt = 1'b0;
    #1;
    checks++;
    if (memoryOut !== model_out) begin
      errors++;
      $display("FAIL halt_hold got %h want %h", memoryOut, model_out);
    end
    do_access(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A, 4, 1'b1, 1'b0, "halt_in_wait");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit          w, r, b;
      logic [15:0] a;
      w = 1'($urandom_range(0, 1));
      r = !w || 1'($urandom_range(0, 1));
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      b = 1'($urandom_range(0, 1));
      do_access(r, w, a, 16'($urandom), 16'($urandom),
                int'($urandom_range(0, TO + 3)), 1'b0, b, "random");
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1, 1'b0, 1'b1, "b2b_0");
    do_access(1'b0, 1'b1, 16'h0102, 16'h2222, 16'h0000, 2, 1'b0, 1'b1, "b2b_1");
    do_access(1'b1, 1'b0, 16'h0104, 16'h0000, 16'h3333, 0, 1'b0, 1'b1, "b2b_2");
    do_access(1'b1, 1'b0, 16'h0106, 16'h0000, 16'h4444, 3, 1'b0, 1'b0, "b2b_3");
  endtask

  initial begin
    test_reset();
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b0, "load_done3");
    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1, 1'b0, 1'b0, "store_done_req");
    do_access(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, "load_timeout");
    do_access(1'b1, 1'b0, 16'h0052, 16'h0000, 16'h7777, TO + 1, 1'b0, 1'b0, "load_last_wait");
    do_access(1'b1, 1'b1, 16'h0060, 16'hABCD, 16'h0000, 2, 1'b0, 1'b0, "both_is_write");
    do_access(1'b1, 1'b0, 16'h0041, 16'h0000, 16'h9876, 2, 1'b0, 1'b0, "odd_addr_load");
    test_reset_mid();
    test_halt();
    test_back_to_back();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_access_ctrl
